// File: rtl/serial_pad_scanner.sv
// serial_pad_scanner
//   Polls a daisy-chained string of shift-register game pads over a
//   three-wire serial link (load strobe, shift clock, data) and presents a
//   debounced, active-high button vector.
//
//   Parameters
//     NUM_PLAYERS     pads on the chain (1-4)
//     BITS_PER_PLAYER button bits per pad (1-16)
//     CLK_DIV         clk cycles per serial half-period (>= 2)
//     DEBOUNCE        identical consecutive scans required before a new
//                     button vector is accepted (1-7, 1 = unfiltered)
//
//   Ports
//     clk       in   system clock
//     reset_n   in   asynchronous active-low reset
//     enable    in   run scans back-to-back while high
//     joy_data  in   serial data from the pad chain, 0 = pressed
//     joy_clk   out  registered serial shift clock
//     joy_load  out  registered parallel-load strobe, active-high
//     joystick  out  debounced buttons, player p at [p*BITS_PER_PLAYER +: BITS_PER_PLAYER]
//     valid     out  one-clk pulse at the end of every completed scan
//     changed   out  one-clk pulse when joystick takes a new value
module serial_pad_scanner #(
  parameter int NUM_PLAYERS     = 2,
  parameter int BITS_PER_PLAYER = 12,
  parameter int CLK_DIV         = 24,
  parameter int DEBOUNCE        = 2
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   enable,
  input  logic                                   joy_data,
  output logic                                   joy_clk,
  output logic                                   joy_load,
  output logic [NUM_PLAYERS*BITS_PER_PLAYER-1:0] joystick,
  output logic                                   valid,
  output logic                                   changed
);

  localparam int TOTAL = NUM_PLAYERS * BITS_PER_PLAYER;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int STB_W = 3;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(TOTAL - 1);
  localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    SHIFT_LO = 3'd2,
    SHIFT_HI = 3'd3,
    UPDATE   = 3'd4
  } state_t;

  state_t             state_q,     state_d;
  logic [DIV_W-1:0]   div_q,       div_d;
  logic               load_half_q, load_half_d;
  logic [BIT_W-1:0]   bit_cnt_q,   bit_cnt_d;
  logic [TOTAL-1:0]   raw_q,       raw_d;
  logic [TOTAL-1:0]   prev_raw_q,  prev_raw_d;
  logic [STB_W-1:0]   stable_q,    stable_d;
  logic [TOTAL-1:0]   joystick_q,  joystick_d;
  logic               valid_q,     valid_d;
  logic               changed_q,   changed_d;
  logic               joy_clk_q,   joy_clk_d;
  logic               joy_load_q,  joy_load_d;
  logic [1:0]         rst_sync_q,  rst_sync_d;
  logic [1:0]         data_sync_q, data_sync_d;

  logic tick;
  logic run_ok;

  // Reset release is re-timed through two flops so the FSM never leaves
  // IDLE on a clock edge that races the deassertion of reset_n.
  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign run_ok     = rst_sync_q[1];

  // joy_data comes from off-chip; two flops guard against metastability.
  // The pad updates its output on the rising joy_clk at the start of the
  // preceding high phase, so the two-cycle delay still lands inside the
  // stable window for any CLK_DIV >= 2.
  assign data_sync_d = {data_sync_q[0], joy_data};

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    state_d     = state_q;
    div_d       = '0;
    load_half_d = load_half_q;
    bit_cnt_d   = bit_cnt_q;
    raw_d       = raw_q;
    prev_raw_d  = prev_raw_q;
    stable_d    = stable_q;
    joystick_d  = joystick_q;
    valid_d     = 1'b0;
    changed_d   = 1'b0;

    // Divider free-runs in the serial phases; IDLE and UPDATE hold it at 0
    // so every LOAD starts from a cleared divider.
    if (state_q == LOAD || state_q == SHIFT_LO || state_q == SHIFT_HI) begin
      div_d = tick ? '0 : div_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (enable && run_ok) begin
          state_d     = LOAD;
          load_half_d = 1'b0;
        end
      end

      LOAD: begin
        if (tick) begin
          if (load_half_q) begin
            state_d     = SHIFT_LO;
            bit_cnt_d   = '0;
            load_half_d = 1'b0;
          end else begin
            load_half_d = 1'b1;
          end
        end
      end

      SHIFT_LO: begin
        if (tick) begin
          raw_d[bit_cnt_q] = ~data_sync_q[1];
          state_d          = SHIFT_HI;
        end
      end

      SHIFT_HI: begin
        if (tick) begin
          if (bit_cnt_q == BIT_LAST) begin
            // raw is complete here (last bit captured at the end of the
            // previous low phase), so the scan is judged on the edge into
            // UPDATE and its results are visible for the whole UPDATE clk.
            state_d    = UPDATE;
            valid_d    = 1'b1;
            prev_raw_d = raw_q;
            if (raw_q == prev_raw_q) begin
              stable_d = (stable_q >= STB_MAX) ? STB_MAX : stable_q + 1'b1;
            end else begin
              stable_d = STB_W'(1);
            end
            if (stable_d >= STB_MAX && raw_q != joystick_q) begin
              joystick_d = raw_q;
              changed_d  = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            state_d   = SHIFT_LO;
          end
        end
      end

      UPDATE: begin
        state_d = enable ? LOAD : IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Pad strobes are decoded from the next state and registered, so they
    // are glitch-free and line up exactly with the state they belong to.
    joy_load_d = (state_d == LOAD);
    joy_clk_d  = (state_d == SHIFT_HI);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      div_q       <= '0;
      load_half_q <= 1'b0;
      bit_cnt_q   <= '0;
      raw_q       <= '0;
      prev_raw_q  <= '0;
      stable_q    <= '0;
      joystick_q  <= '0;
      valid_q     <= 1'b0;
      changed_q   <= 1'b0;
      joy_clk_q   <= 1'b0;
      joy_load_q  <= 1'b0;
      rst_sync_q  <= 2'b00;
      data_sync_q <= 2'b11;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      load_half_q <= load_half_d;
      bit_cnt_q   <= bit_cnt_d;
      raw_q       <= raw_d;
      prev_raw_q  <= prev_raw_d;
      stable_q    <= stable_d;
      joystick_q  <= joystick_d;
      valid_q     <= valid_d;
      changed_q   <= changed_d;
      joy_clk_q   <= joy_clk_d;
      joy_load_q  <= joy_load_d;
      rst_sync_q  <= rst_sync_d;
      data_sync_q <= data_sync_d;
    end
  end

  assign joy_clk  = joy_clk_q;
  assign joy_load = joy_load_q;
  assign joystick = joystick_q;
  assign valid    = valid_q;
  assign changed  = changed_q;

endmodule

// File: tb/tb_serial_pad_scanner.sv
// tb_serial_pad_scanner
//   Bench for serial_pad_scanner with 2 pads x 4 bits, CLK_DIV=2 (37-clk
//   scans). dut runs with DEBOUNCE=2, dut1 with DEBOUNCE=1. Each DUT has a
//   behavioural pad chain that latches a pressed-bit pattern on joy_load
//   and presents bit k after k rising joy_clk edges (active-low data).
module tb_serial_pad_scanner;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable, enable1;
  logic       joy_data, joy_data1;
  logic       joy_clk, joy_clk1;
  logic       joy_load, joy_load1;
  logic [7:0] joystick, joystick1;
  logic       valid, valid1;
  logic       changed, changed1;

  always #5 clk = ~clk;

  serial_pad_scanner #(.NUM_PLAYERS(2), .BITS_PER_PLAYER(4), .CLK_DIV(2), .DEBOUNCE(2)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .joy_data(joy_data),
    .joy_clk(joy_clk), .joy_load(joy_load), .joystick(joystick),
    .valid(valid), .changed(changed));

  serial_pad_scanner #(.NUM_PLAYERS(2), .BITS_PER_PLAYER(4), .CLK_DIV(2), .DEBOUNCE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .enable(enable1), .joy_data(joy_data1),
    .joy_clk(joy_clk1), .joy_load(joy_load1), .joystick(joystick1),
    .valid(valid1), .changed(changed1));

  // Pad chain models
  logic [7:0] pad_pat = 8'h00, pad_lat = 8'h00;
  logic [7:0] pad1_pat = 8'h00, pad1_lat = 8'h00;
  int pad_idx = 8, pad1_idx = 8;

  always @(posedge joy_load or posedge joy_clk) begin
    if (joy_load) begin pad_idx = 0; pad_lat = pad_pat; end
    else pad_idx = pad_idx + 1;
  end
  always @(posedge joy_load1 or posedge joy_clk1) begin
    if (joy_load1) begin pad1_idx = 0; pad1_lat = pad1_pat; end
    else pad1_idx = pad1_idx + 1;
  end
  assign joy_data  = (pad_idx  < 8) ? ~pad_lat[pad_idx[2:0]]   : 1'b1;
  assign joy_data1 = (pad1_idx < 8) ? ~pad1_lat[pad1_idx[2:0]] : 1'b1;

  // Activity counters, sampled at posedge (values of the cycle just ended)
  int chg_cnt = 0, jclk_rises = 0, joy_outside = 0;
  logic [7:0] joy_last = 8'h00;
  logic jclk_last = 1'b0;
  always @(posedge clk) begin
    if (changed === 1'b1) chg_cnt = chg_cnt + 1;
    if (joy_clk === 1'b1 && jclk_last === 1'b0) jclk_rises = jclk_rises + 1;
    jclk_last = joy_clk;
    if (reset_n === 1'b1 && joystick !== joy_last && valid !== 1'b1) joy_outside = joy_outside + 1;
    joy_last = joystick;
  end

  // Reference debounce model: rules applied per completed scan
  typedef struct {
    logic [7:0] prev;
    int         stable;
    logic [7:0] joy;
  } model_t;

  model_t m, m1;

  function automatic void model_step(inout model_t s, input logic [7:0] raw,
                                     input int deb, output logic chg);
    if (raw == s.prev) s.stable = (s.stable < deb) ? s.stable + 1 : deb;
    else               s.stable = 1;
    s.prev = raw;
    chg = (s.stable >= deb) && (raw != s.joy);
    if (chg) s.joy = raw;
  endfunction

  int n_checks = 0;
  int n_pass   = 0;

  task automatic wait_valid(input int which, input int budget, output bit to, output int n);
    to = 1'b1;
    n  = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      n = n + 1;
      if (((which == 0) ? valid : valid1) === 1'b1) begin to = 1'b0; break; end
    end
  endtask

  task automatic test_reset;
    int bad;
    reset_n = 1'b0; enable = 1'b0; enable1 = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if ({joystick, valid, changed, joy_clk, joy_load} !== 12'h000)
      $display("FAIL reset_outputs: got joy=%h v=%b c=%b clk=%b ld=%b want all 0", joystick, valid, changed, joy_clk, joy_load);
    else n_pass++;
    n_checks++; if ({joystick1, valid1, changed1, joy_clk1, joy_load1} !== 12'h000)
      $display("FAIL reset_outputs1: got joy=%h v=%b c=%b want all 0", joystick1, valid1, changed1);
    else n_pass++;
    reset_n = 1'b1;
    bad = 0;
    repeat (6) begin @(negedge clk); if (joy_load !== 1'b0 || joy_clk !== 1'b0) bad++; end
    n_checks++; if (bad !== 0) $display("FAIL idle_without_enable: got %0d active cycles want 0", bad);
    else n_pass++;
    m = '{prev: 8'h00, stable: 0, joy: 8'h00};
    m1 = '{prev: 8'h00, stable: 0, joy: 8'h00};
  endtask

  task automatic test_timing;
    bit ld [0:79]; bit ck [0:79]; bit vd [0:79];
    int run, err, vcnt, rise2, both, c0, n;
    bit to;
    pad_pat = 8'h00;
    c0 = chg_cnt;
    enable = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      ld[i] = joy_load; ck[i] = joy_clk; vd[i] = valid;
      n_checks++; if (joystick !== 8'h00) $display("FAIL timing_joystick: got %h want 00 at %0d", joystick, i);
      else n_pass++;
    end
    n_checks++; if (ld[0] !== 1'b1) $display("FAIL load_next_clk: got %b want 1", ld[0]); else n_pass++;
    run = 0;
    for (int i = 0; i < 80; i++) begin if (!ld[i]) break; run++; end
    n_checks++; if (run !== 4) $display("FAIL load_width: got %0d want 4", run); else n_pass++;
    err = 0;
    for (int b = 0; b < 8; b++)
      for (int c = 0; c < 4; c++) begin
        if (ck[4 + 4*b + c] !== (c >= 2)) err++;
        if (ld[4 + 4*b + c] !== 1'b0) err++;
      end
    n_checks++; if (err !== 0) $display("FAIL clk_pattern: got %0d bad cycles want 0", err); else n_pass++;
    vcnt = 0;
    for (int i = 0; i <= 36; i++) if (vd[i]) vcnt++;
    n_checks++; if (vcnt !== 1 || vd[36] !== 1'b1)
      $display("FAIL valid_once: got count %0d at36=%b want 1 at 36", vcnt, vd[36]);
    else n_pass++;
    rise2 = -1;
    for (int i = 1; i < 80; i++) if (ld[i] && !ld[i-1]) begin rise2 = i; break; end
    n_checks++; if (rise2 !== 37) $display("FAIL scan_period: got %0d want 37", rise2); else n_pass++;
    both = 0;
    for (int i = 0; i < 80; i++) if (ld[i] && ck[i]) both++;
    n_checks++; if (both !== 0) $display("FAIL load_clk_overlap: got %0d want 0", both); else n_pass++;
    enable = 1'b0;
    wait_valid(0, 60, to, n);
    n_checks++; if (to) $display("FAIL timing_drain: got timeout want valid"); else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++; if (chg_cnt - c0 !== 0) $display("FAIL timing_changed: got %0d pulses want 0", chg_cnt - c0);
    else n_pass++;
    // Three identical all-released scans since reset
    m = '{prev: 8'h00, stable: 2, joy: 8'h00};
  endtask

  task automatic test_mapping;
    logic ec; bit to; int n;
    pad_pat = 8'hA1;
    enable = 1'b1;
    for (int s = 0; s < 3; s++) begin
      wait_valid(0, 60, to, n);
      n_checks++; if (to) $display("FAIL map_timeout: scan %0d got timeout want valid", s); else n_pass++;
      model_step(m, 8'hA1, 2, ec);
      n_checks++; if (joystick !== m.joy) $display("FAIL map_joystick: scan %0d got %h want %h", s, joystick, m.joy);
      else n_pass++;
      n_checks++; if (changed !== ec) $display("FAIL map_changed: scan %0d got %b want %b", s, changed, ec);
      else n_pass++;
    end
    n_checks++; if (joystick !== 8'hA1) $display("FAIL map_final: got %h want a1", joystick); else n_pass++;
  endtask

  task automatic test_glitch;
    logic [7:0] seq [0:2];
    logic ec; bit to; int n, c0;
    seq[0] = 8'h0F; seq[1] = 8'hA1; seq[2] = 8'hA1;
    @(posedge clk); #1;
    c0 = chg_cnt;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      pad_pat = seq[s];
      wait_valid(0, 60, to, n);
      n_checks++; if (to) $display("FAIL glitch_timeout: scan %0d got timeout want valid", s); else n_pass++;
      model_step(m, seq[s], 2, ec);
      n_checks++; if (joystick !== 8'hA1 || joystick !== m.joy)
        $display("FAIL glitch_joystick: scan %0d got %h want a1", s, joystick);
      else n_pass++;
      n_checks++; if (changed !== ec) $display("FAIL glitch_changed: scan %0d got %b want %b", s, changed, ec);
      else n_pass++;
    end
    repeat (2) @(negedge clk);
    n_checks++; if (chg_cnt - c0 !== 0) $display("FAIL glitch_pulses: got %0d want 0", chg_cnt - c0);
    else n_pass++;
    // Realign to a scan boundary
    wait_valid(0, 60, to, n);
    model_step(m, 8'hA1, 2, ec);
  endtask

  task automatic test_enable_drop;
    logic ec; bit to; int n, r0, bad;
    pad_pat = 8'hA1;
    r0 = jclk_rises;
    repeat (17) @(negedge clk);
    n_checks++; if (joy_clk !== 1'b0 || joy_load !== 1'b0)
      $display("FAIL drop_phase: got clk=%b ld=%b want 0 0", joy_clk, joy_load);
    else n_pass++;
    enable = 1'b0;
    wait_valid(0, 40, to, n);
    n_checks++; if (to || n !== 20) $display("FAIL drop_complete: got %0d clks to=%b want 20", n, to);
    else n_pass++;
    model_step(m, 8'hA1, 2, ec);
    n_checks++; if (jclk_rises - r0 !== 8) $display("FAIL drop_bits: got %0d clk pulses want 8", jclk_rises - r0);
    else n_pass++;
    n_checks++; if (joystick !== m.joy) $display("FAIL drop_joystick: got %h want %h", joystick, m.joy);
    else n_pass++;
    bad = 0;
    repeat (6) begin @(negedge clk); if (joy_clk !== 1'b0 || joy_load !== 1'b0 || valid !== 1'b0) bad++; end
    n_checks++; if (bad !== 0) $display("FAIL drop_idle: got %0d active cycles want 0", bad); else n_pass++;
    enable = 1'b1;
    @(negedge clk);
    n_checks++; if (joy_load !== 1'b1) $display("FAIL reenable_load: got %b want 1", joy_load); else n_pass++;
  endtask

  task automatic test_reset_midscan;
    logic ec; bit to, seen; int n;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (joy_clk === 1'b1) begin seen = 1'b1; break; end
    end
    n_checks++; if (!seen) $display("FAIL rst_find_hi: got no joy_clk high want high"); else n_pass++;
    #1 reset_n = 1'b0;
    #1;
    n_checks++; if ({joy_clk, joy_load, valid, joystick} !== 11'h000)
      $display("FAIL rst_async: got clk=%b ld=%b v=%b joy=%h want 0", joy_clk, joy_load, valid, joystick);
    else n_pass++;
    m  = '{prev: 8'h00, stable: 0, joy: 8'h00};
    m1 = '{prev: 8'h00, stable: 0, joy: 8'h00};
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++; if (joy_load !== 1'b0) $display("FAIL rst_sync: got load %b one clk after release want 0", joy_load);
    else n_pass++;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (joy_load === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++; if (!seen) $display("FAIL rst_restart: got no joy_load want load"); else n_pass++;
    wait_valid(0, 60, to, n);
    n_checks++; if (to) $display("FAIL rst_scan: got timeout want valid"); else n_pass++;
    model_step(m, 8'hA1, 2, ec);
    n_checks++; if (joystick !== m.joy || changed !== ec)
      $display("FAIL rst_first_scan: got %h/%b want %h/%b", joystick, changed, m.joy, ec);
    else n_pass++;
  endtask

  task automatic test_random;
    logic [7:0] p; logic ec; bit to; int n, rep, c0, exp_chg;
    c0 = chg_cnt - (changed === 1'b1 ? 1 : 0);
    exp_chg = 0;
    for (int k = 0; k < 10; k++) begin
      case ($urandom_range(0, 4))
        0: p = 8'hA1;
        1: p = 8'h5A;
        2: p = 8'h00;
        default: p = 8'($urandom());
      endcase
      rep = $urandom_range(1, 3);
      for (int r = 0; r < rep; r++) begin
        pad_pat = p;
        wait_valid(0, 60, to, n);
        n_checks++; if (to) $display("FAIL rand_timeout: got timeout want valid"); else n_pass++;
        model_step(m, p, 2, ec);
        if (ec) exp_chg++;
        n_checks++; if (joystick !== m.joy || changed !== ec)
          $display("FAIL rand_scan: pat %h got %h/%b want %h/%b", p, joystick, changed, m.joy, ec);
        else n_pass++;
      end
    end
    enable = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (chg_cnt - c0 !== exp_chg) $display("FAIL rand_pulses: got %0d want %0d", chg_cnt - c0, exp_chg);
    else n_pass++;
    n_checks++; if (joy_outside !== 0) $display("FAIL joy_hold: got %0d changes outside update want 0", joy_outside);
    else n_pass++;
    n_checks++; if (joy_load !== 1'b0 || joy_clk !== 1'b0) $display("FAIL rand_idle: got ld=%b clk=%b want 0 0", joy_load, joy_clk);
    else n_pass++;
  endtask

  task automatic test_debounce1;
    logic [7:0] seq [0:2];
    logic ec; bit to; int n;
    seq[0] = 8'hA1; seq[1] = 8'h5A; seq[2] = 8'h5A;
    pad1_pat = seq[0];
    enable1 = 1'b1;
    for (int s = 0; s < 3; s++) begin
      pad1_pat = seq[s];
      wait_valid(1, 60, to, n);
      n_checks++; if (to) $display("FAIL deb1_timeout: scan %0d got timeout want valid", s); else n_pass++;
      model_step(m1, seq[s], 1, ec);
      n_checks++; if (joystick1 !== m1.joy || changed1 !== ec)
        $display("FAIL deb1_scan: scan %0d got %h/%b want %h/%b", s, joystick1, changed1, m1.joy, ec);
      else n_pass++;
      if (s == 1) begin
        n_checks++; if (joystick1 !== 8'h5A || changed1 !== 1'b1)
          $display("FAIL deb1_immediate: got %h/%b want 5a/1", joystick1, changed1);
        else n_pass++;
      end
    end
    enable1 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got no completion want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_timing();
    test_mapping();
    test_glitch();
    test_enable_drop();
    test_reset_midscan();
    test_random();
    test_debounce1();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
